jtkcpu_idx_seq: RTL and testbench
=================================

JTKCPU_IDX_SEQ -- requirements
Module: jtkcpu_idx_seq

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 start  in  1  one-cycle request to resolve one indexed operand; sampled only in IDLE.
REQ-005 postbyte  in  8  indexing postbyte; held stable by the requester from start until done.
REQ-006 pc  in  16  address of first operand byte after the postbyte; held stable from start until done.
REQ-007 idx_reg  in  16  current value of the selected index register.
REQ-008 idx_addr  in  16  registered sum from the index-address calculator; valid one cycle after data is stable.
REQ-009 data  out  16  offset/extended-address word fed to the index-address calculator.
REQ-010 bus_rd  out  1  byte read request; bus_addr  out  16  read address; bus_din  in  8  read byte; bus_ack  in  1  read completes.
REQ-011 reg_we  out  1  index-register write strobe; reg_wdata  out  16; reg_sel  out  3  = {postbyte[1], postbyte[6:5]}.
REQ-012 ea  out  16  final effective address; pc_adv  out  2  operand bytes consumed (0..2); done  out  1  one-cycle completion pulse; busy  out  1  high when not IDLE.

Function
REQ-013 Mode decode (postbyte[7]=0): postbyte[3:0] in {1000,1100} SHALL need 1 offset byte; {1001,1101,1111} SHALL need 2; all others SHALL need 0; postbyte[7]=1 SHALL need 0.
REQ-014 Indirect SHALL be active only when postbyte[7]=0 and postbyte[4]=1.
REQ-015 States: IDLE, OFS_HI, OFS_LO, CALC, ADDR, IND_HI, IND_LO.
REQ-016 IDLE + start: 2 bytes -> OFS_HI; 1 byte -> OFS_LO; 0 bytes -> CALC. data SHALL be cleared to 0 on start acceptance.
REQ-017 OFS_HI reads pc, stores bus_din into data[15:8] -> OFS_LO; OFS_LO reads pc+1 (2-byte) or pc (1-byte), stores bus_din into data[7:0] -> CALC. 1-byte mode: data[15:8]=0.
REQ-018 Bus handshake: bus_rd and bus_addr SHALL stay constant until the edge where bus_ack=1; the byte SHALL be captured on that edge; bus_ack while bus_rd=0 SHALL be ignored; wait states unbounded.
REQ-019 CALC SHALL last exactly 1 cycle with data stable -> ADDR.
REQ-020 ADDR address select: mode 1111 (postbyte[7]=0) -> data; modes 0000/0001 -> idx_reg (post-increment); all others -> idx_addr.
REQ-021 ADDR: modes 0000..0011 with postbyte[7]=0 SHALL pulse reg_we for 1 cycle with reg_wdata=idx_addr; no other mode SHALL assert reg_we.
REQ-022 ADDR: indirect -> IND_HI with pointer latched; otherwise ea <= selected address, done pulse, -> IDLE.
REQ-023 IND_HI reads pointer, stores high byte; IND_LO reads pointer+1 (16-bit wrap), ea <= {hi, bus_din}, done pulse, -> IDLE.
REQ-024 done SHALL be high exactly one cycle, registered, coincident with ea and pc_adv valid; ea and pc_adv SHALL hold until next done.
REQ-025 start while busy SHALL be ignored; start in same cycle as done SHALL be ignored (block not yet IDLE).
REQ-026 All address arithmetic SHALL be 16-bit modulo (pc+1 of FFFF = 0000).

Reset
REQ-027 rst_n low SHALL immediately force IDLE and drive bus_rd, reg_we, done, busy = 0; data, ea, bus_addr, reg_wdata, pc_adv = 0.
REQ-028 Reset mid-operation SHALL abandon the transfer without reg_we or done; first start after rst_n rises SHALL be accepted normally.

Verification
REQ-029 postbyte=8'h84 (5-bit, 0 bytes), idx_reg=1000, idx_addr=0FFC, start at edge E0 -> done high E2..E3, ea=0FFC, pc_adv=0, no bus_rd.
REQ-030 postbyte=8'h09 (16-bit), pc=2000, mem[2000]=12, mem[2001]=34, ack 2 wait states each -> data=1234, bus_rd held with addr stable during waits, pc_adv=2.
REQ-031 postbyte=8'h00 (post-inc), idx_reg=4000, idx_addr=4001 -> ea=4000, reg_we one cycle with reg_wdata=4001, reg_sel=000.
REQ-032 postbyte=8'h1F (extended indirect), pc=FFFF, mem[FFFF]=30, mem[0000]=00, mem[3000]=AB, mem[3001]=CD -> reads FFFF,0000,3000,3001; ea=ABCD, pc_adv=2.
REQ-033 start repeated every cycle during busy -> only first accepted; one done per accepted start.
REQ-034 rst_n pulsed low during OFS_LO wait -> bus_rd=0 at once, no done, no reg_we; subsequent start completes correctly.

Source files
------------

// File: rtl/jtkcpu_idx_seq.sv
// Indexed-operand sequencer. It fetches the offset bytes that follow an
// indexing postbyte and chooses the base address. For indirect modes it
// also fetches the 16-bit pointer. The effective address is reported with a
// one-cycle done pulse.
module jtkcpu_idx_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  postbyte,
  input  logic [15:0] pc,
  input  logic [15:0] idx_reg,
  input  logic [15:0] idx_addr,
  output logic [15:0] data,
  output logic        bus_rd,
  output logic [15:0] bus_addr,
  input  logic [7:0]  bus_din,
  input  logic        bus_ack,
  output logic        reg_we,
  output logic [15:0] reg_wdata,
  output logic [2:0]  reg_sel,
  output logic [15:0] ea,
  output logic [1:0]  pc_adv,
  output logic        done,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, OFS_HI, OFS_LO, CALC, ADDR, IND_HI, IND_LO
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] data_q, data_d;
  logic        bus_rd_q, bus_rd_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic        reg_we_q, reg_we_d;
  logic [15:0] reg_wdata_q, reg_wdata_d;
  logic [15:0] ea_q, ea_d;
  logic [1:0]  pc_adv_q, pc_adv_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [1:0]  n_bytes_q, n_bytes_d;
  logic [7:0]  ptr_hi_q, ptr_hi_d;

  logic [3:0]  mode;
  logic [1:0]  n_bytes;
  logic        indirect;
  logic        wb_mode;
  logic [15:0] sel_addr;

  assign mode     = postbyte[3:0];
  assign indirect = ~postbyte[7] & postbyte[4];
  // Auto-increment/decrement modes write the updated index register back.
  assign wb_mode  = ~postbyte[7] & (mode[3:2] == 2'b00);
  assign reg_sel  = {postbyte[1], postbyte[6:5]};

  // Number of operand bytes that follow the postbyte.
  always_comb begin
    n_bytes = 2'd0;
    if (!postbyte[7]) begin
      case (mode)
        4'h8, 4'hC:       n_bytes = 2'd1;
        4'h9, 4'hD, 4'hF: n_bytes = 2'd2;
        default:          n_bytes = 2'd0;
      endcase
    end
  end

  // Base address: extended mode uses the fetched word directly. Post-increment
  // uses the register value before the update. Every other mode takes the
  // calculator's sum.
  always_comb begin
    if (!postbyte[7] && mode == 4'hF)      sel_addr = data_q;
    else if (!postbyte[7] && mode[3:1] == 3'b000) sel_addr = idx_reg;
    else                                   sel_addr = idx_addr;
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    // NOTE: every _d starts from a default so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    data_d      = data_q;
    bus_rd_d    = bus_rd_q;
    bus_addr_d  = bus_addr_q;
    reg_we_d    = 1'b0;
    reg_wdata_d = reg_wdata_q;
    ea_d        = ea_q;
    pc_adv_d    = pc_adv_q;
    done_d      = 1'b0;
    n_bytes_d   = n_bytes_q;
    ptr_hi_d    = ptr_hi_q;

    case (state_q)
      IDLE: begin
        // While done is high, the previous operation is still closing out,
        // so a start in that cycle is not taken.
        if (start && !done_q) begin
          data_d    = 16'h0000;
          n_bytes_d = n_bytes;
          case (n_bytes)
            2'd2: begin
              state_d    = OFS_HI;
              bus_rd_d   = 1'b1;
              bus_addr_d = pc;
            end
            2'd1: begin
              state_d    = OFS_LO;
              bus_rd_d   = 1'b1;
              bus_addr_d = pc;
            end
            default: state_d = CALC;
          endcase
        end
      end
      OFS_HI: begin
        if (bus_ack) begin
          data_d[15:8] = bus_din;
          bus_addr_d   = pc + 16'd1;
          state_d      = OFS_LO;
        end
      end
      OFS_LO: begin
        if (bus_ack) begin
          data_d[7:0] = bus_din;
          bus_rd_d    = 1'b0;
          state_d     = CALC;
        end
      end
      CALC: state_d = ADDR;
      ADDR: begin
        if (wb_mode) begin
          reg_we_d    = 1'b1;
          reg_wdata_d = idx_addr;
        end
        if (indirect) begin
          bus_rd_d   = 1'b1;
          bus_addr_d = sel_addr;
          state_d    = IND_HI;
        end else begin
          ea_d     = sel_addr;
          pc_adv_d = n_bytes_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      IND_HI: begin
        if (bus_ack) begin
          ptr_hi_d   = bus_din;
          bus_addr_d = bus_addr_q + 16'd1;
          state_d    = IND_LO;
        end
      end
      IND_LO: begin
        if (bus_ack) begin
          ea_d     = {ptr_hi_q, bus_din};
          pc_adv_d = n_bytes_q;
          bus_rd_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE) | done_d;
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= 16'h0000;
      bus_rd_q    <= 1'b0;
      bus_addr_q  <= 16'h0000;
      reg_we_q    <= 1'b0;
      reg_wdata_q <= 16'h0000;
      ea_q        <= 16'h0000;
      pc_adv_q    <= 2'd0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      n_bytes_q   <= 2'd0;
      ptr_hi_q    <= 8'h00;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      data_q      <= data_d;
      bus_rd_q    <= bus_rd_d;
      bus_addr_q  <= bus_addr_d;
      reg_we_q    <= reg_we_d;
      reg_wdata_q <= reg_wdata_d;
      ea_q        <= ea_d;
      pc_adv_q    <= pc_adv_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      n_bytes_q   <= n_bytes_d;
      ptr_hi_q    <= ptr_hi_d;
    end
  end

  assign data      = data_q;
  assign bus_rd    = bus_rd_q;
  assign bus_addr  = bus_addr_q;
  assign reg_we    = reg_we_q;
  assign reg_wdata = reg_wdata_q;
  assign ea        = ea_q;
  assign pc_adv    = pc_adv_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_jtkcpu_idx_seq.sv
// Bench for jtkcpu_idx_seq. It uses a byte memory with a wait-state
// responder, a registered index-address calculator, and an operand model
// built from the postbyte decoding rules.
module tb_jtkcpu_idx_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  postbyte;
  logic [15:0] pc, idx_reg, idx_addr;
  logic [15:0] data;
  logic        bus_rd;
  logic [15:0] bus_addr;
  logic [7:0]  bus_din;
  logic        bus_ack;
  logic        reg_we;
  logic [15:0] reg_wdata;
  logic [2:0]  reg_sel;
  logic [15:0] ea;
  logic [1:0]  pc_adv;
  logic        done, busy;

  jtkcpu_idx_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .postbyte(postbyte), .pc(pc),
    .idx_reg(idx_reg), .idx_addr(idx_addr), .data(data), .bus_rd(bus_rd),
    .bus_addr(bus_addr), .bus_din(bus_din), .bus_ack(bus_ack),
    .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_sel(reg_sel), .ea(ea),
    .pc_adv(pc_adv), .done(done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] calc_add = 16'h0000;
  int          waits = 0;
  bit          spur = 1'b0;
  logic [15:0] reads_q [$];

  typedef struct {
    logic [15:0] ea;
    logic [15:0] data;
    logic [15:0] wdata;
    logic [1:0]  adv;
    logic        we;
    logic [2:0]  sel;
    int          n_rd;
    logic [15:0] rd [4];
  } exp_t;

  exp_t        cur;
  bit          done_pend = 1'b0;
  bit          we_pend = 1'b0;
  int          done_seen = 0;
  int          we_seen = 0;
  logic [15:0] held_ea = 16'h0000;
  logic [1:0]  held_adv = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Operand model built from the postbyte decoding rules.
  function automatic exp_t model(input logic [7:0] pb, input logic [15:0] pcv,
                                 input logic [15:0] ir, input logic [15:0] add);
    exp_t        e;
    logic [3:0]  m;
    logic [15:0] p1, calc, base, base1;
    m = pb[3:0];
    e.n_rd = 0;
    for (int i = 0; i < 4; i++) e.rd[i] = 16'h0000;
    if (!pb[7] && (m == 4'h8 || m == 4'hC))                   e.adv = 2'd1;
    else if (!pb[7] && (m == 4'h9 || m == 4'hD || m == 4'hF)) e.adv = 2'd2;
    else                                                      e.adv = 2'd0;
    p1 = pcv + 16'd1;
    if (e.adv == 2'd2) begin
      e.data = {mem[pcv], mem[p1]};
      e.rd[0] = pcv; e.rd[1] = p1; e.n_rd = 2;
    end else if (e.adv == 2'd1) begin
      e.data = {8'h00, mem[pcv]};
      e.rd[0] = pcv; e.n_rd = 1;
    end else begin
      e.data = 16'h0000;
    end
    calc = e.data + add;
    if (!pb[7] && m == 4'hF)       base = e.data;
    else if (!pb[7] && m <= 4'h1)  base = ir;
    else                           base = calc;
    e.we    = !pb[7] && (m <= 4'h3);
    e.wdata = calc;
    e.sel   = {pb[1], pb[6:5]};
    if (!pb[7] && pb[4]) begin
      base1 = base + 16'd1;
      e.ea = {mem[base], mem[base1]};
      e.rd[e.n_rd] = base; e.rd[e.n_rd + 1] = base1; e.n_rd += 2;
    end else begin
      e.ea = base;
    end
    return e;
  endfunction

  // Registered index-address calculator: idx_addr = previous data + addend.
  initial begin
    logic [15:0] dprev;
    dprev = 16'h0000;
    idx_addr = 16'h0000;
    forever begin
      @(negedge clk);
      idx_addr = dprev + calc_add;
      dprev = data;
    end
  end

  // Memory responder with programmable wait states and optional stray acks.
  initial begin
    int          cnt;
    bit          in_req;
    logic [15:0] raddr;
    cnt = 0; in_req = 1'b0; raddr = 16'h0000;
    bus_ack = 1'b0; bus_din = 8'h00;
    forever begin
      @(negedge clk);
      bus_ack = 1'b0;
      bus_din = 8'h00;
      if (!rst_n) begin
        in_req = 1'b0;
      end else if (bus_rd) begin
        if (!in_req) begin
          in_req = 1'b1; cnt = 0; raddr = bus_addr;
          reads_q.push_back(bus_addr);
        end else begin
          check("bus_addr_stable", bus_addr, raddr);
        end
        if (cnt == waits) begin
          bus_ack = 1'b1; bus_din = mem[bus_addr]; in_req = 1'b0;
        end else begin
          cnt++;
        end
      end else begin
        if (in_req) check("bus_rd_dropped", bus_rd, 1'b1);
        in_req = 1'b0;
        if (spur) begin bus_ack = 1'b1; bus_din = 8'hEE; end
      end
    end
  end

  // Per-cycle compare: done/reg_we against the model, ea/pc_adv hold otherwise.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (reg_we) begin
          if (!we_pend) check("reg_we_spurious", reg_we, 1'b0);
          else begin
            check("reg_wdata", reg_wdata, cur.wdata);
            check("reg_sel", reg_sel, cur.sel);
            we_pend = 1'b0;
            we_seen++;
          end
        end
        if (done) begin
          if (!done_pend) check("done_spurious", done, 1'b0);
          else begin
            check("ea", ea, cur.ea);
            check("pc_adv", pc_adv, cur.adv);
            check("data", data, cur.data);
            held_ea = cur.ea; held_adv = cur.adv;
            done_pend = 1'b0;
            done_seen++;
          end
        end else begin
          check("ea_hold", ea, held_ea);
          check("pc_adv_hold", pc_adv, held_adv);
        end
      end
    end
  end

  // One operation: set up inputs, pulse (or hold) start, wait for done, check.
  task automatic run_op(input logic [7:0] pb, input logic [15:0] pcv,
                        input logic [15:0] ir, input logic [15:0] add,
                        input int w, input bit sp, input bit hold, output int lat);
    int d0, w0;
    postbyte = pb; pc = pcv; idx_reg = ir; calc_add = add; waits = w; spur = sp;
    @(negedge clk);
    cur = model(pb, pcv, ir, add);
    reads_q.delete();
    d0 = done_seen; w0 = we_seen;
    done_pend = 1'b1; we_pend = cur.we;
    start = 1'b1;
    lat = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (!hold) start = 1'b0;
      if (done) break;
    end
    if (!done) begin
      check("done_timeout", done, 1'b1);
      done_pend = 1'b0; we_pend = 1'b0;
    end
    if (hold) begin
      @(negedge clk);
      start = 1'b0;
    end
    spur = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("done_count", done_seen - d0, 1);
    check("reg_we_count", we_seen - w0, {31'd0, cur.we});
    check("busy_idle", busy, 1'b0);
    check("read_count", reads_q.size(), cur.n_rd);
    for (int i = 0; i < cur.n_rd && i < reads_q.size(); i++)
      check("read_addr", reads_q[i], cur.rd[i]);
  endtask

  initial begin
    int lat;
    start = 1'b0; postbyte = 8'h00; pc = 16'h0000; idx_reg = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h2000] = 8'h12; mem[16'h2001] = 8'h34;
    mem[16'hFFFF] = 8'h30; mem[16'h0000] = 8'h00;
    mem[16'h3000] = 8'hAB; mem[16'h3001] = 8'hCD;
    mem[16'h5000] = 8'h80; mem[16'h4F80] = 8'h5A; mem[16'h4F81] = 8'hA5;
    mem[16'h0C00] = 8'h11; mem[16'h0C01] = 8'h22;
    mem[16'h0200] = 8'hDE; mem[16'h0201] = 8'hAD;
    mem[16'h0300] = 8'hF0;
    mem[16'h7000] = 8'h01; mem[16'h7001] = 8'h02;
    mem[16'h6000] = 8'h44;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("rst_bus_rd", bus_rd, 1'b0);
    check("rst_reg_we", reg_we, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_data", data, 16'h0000);
    check("rst_ea", ea, 16'h0000);
    check("rst_bus_addr", bus_addr, 16'h0000);
    check("rst_reg_wdata", reg_wdata, 16'h0000);
    check("rst_pc_adv", pc_adv, 2'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 5-bit offset mode, no operand bytes.
    run_op(8'h84, 16'h1234, 16'h1000, 16'h0FFC, 0, 1'b0, 1'b0, lat);
    check("r029_latency", lat, 3);
    check("r029_ea", ea, 16'h0FFC);
    check("r029_pc_adv", pc_adv, 2'd0);

    // 16-bit offset with two wait states per byte.
    run_op(8'h09, 16'h2000, 16'h0100, 16'h0100, 2, 1'b0, 1'b0, lat);
    check("r030_data", data, 16'h1234);
    check("r030_ea", ea, 16'h1334);
    check("r030_pc_adv", pc_adv, 2'd2);

    // Post-increment.
    run_op(8'h00, 16'h0000, 16'h4000, 16'h4001, 0, 1'b0, 1'b0, lat);
    check("r031_ea", ea, 16'h4000);
    check("r031_wdata", reg_wdata, 16'h4001);
    check("r031_sel", reg_sel, 3'b000);

    // Pre-decrement-style write-back mode with a non-zero register select.
    run_op(8'h43, 16'h0000, 16'h8000, 16'h9000, 1, 1'b0, 1'b0, lat);
    check("wb_sel", reg_sel, 3'b110);
    check("wb_ea", ea, 16'h9000);

    // Extended indirect with wrap of pc+1.
    run_op(8'h1F, 16'hFFFF, 16'h0000, 16'h0000, 1, 1'b0, 1'b0, lat);
    check("r032_ea", ea, 16'hABCD);
    check("r032_pc_adv", pc_adv, 2'd2);
    check("r032_rd0", reads_q[0], 16'hFFFF);
    check("r032_rd1", reads_q[1], 16'h0000);
    check("r032_rd2", reads_q[2], 16'h3000);
    check("r032_rd3", reads_q[3], 16'h3001);

    // 8-bit offset indirect with stray acks while the bus is idle.
    run_op(8'h18, 16'h5000, 16'h0000, 16'h4F00, 0, 1'b1, 1'b0, lat);
    check("ind8_ea", ea, 16'h5AA5);

    // 8-bit offset direct with stray acks.
    run_op(8'h0C, 16'h0300, 16'h0000, 16'h0100, 0, 1'b1, 1'b0, lat);
    check("ofs8_ea", ea, 16'h01F0);
    check("ofs8_data", data, 16'h00F0);

    // Post-increment indirect.
    run_op(8'h11, 16'h0000, 16'h0C00, 16'h0C02, 1, 1'b0, 1'b0, lat);
    check("pinc_ind_ea", ea, 16'h1122);

    // Low nibble 1111 with postbyte[7]=1 is not extended mode.
    run_op(8'h8F, 16'h0000, 16'h0000, 16'h7777, 0, 1'b0, 1'b0, lat);
    check("b7_ea", ea, 16'h7777);

    // Extended direct.
    run_op(8'h0F, 16'h0200, 16'h0000, 16'h5555, 0, 1'b0, 1'b0, lat);
    check("ext_ea", ea, 16'hDEAD);

    // start held high throughout busy and through the done cycle.
    run_op(8'h0D, 16'h7000, 16'h0000, 16'h0010, 1, 1'b0, 1'b1, lat);
    check("r033_ea", ea, 16'h0112);

    // Reset during the OFS_LO wait.
    postbyte = 8'h08; pc = 16'h6000; calc_add = 16'h0000; waits = 6;
    done_pend = 1'b0; we_pend = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("r034_rd_before", bus_rd, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("r034_bus_rd", bus_rd, 1'b0);
    check("r034_done", done, 1'b0);
    check("r034_reg_we", reg_we, 1'b0);
    check("r034_busy", busy, 1'b0);
    check("r034_ea", ea, 16'h0000);
    check("r034_pc_adv", pc_adv, 2'd0);
    held_ea = 16'h0000; held_adv = 2'd0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run_op(8'h08, 16'h6000, 16'h0000, 16'h1000, 1, 1'b0, 1'b0, lat);
    check("r034_after_ea", ea, 16'h1044);
    check("r034_after_adv", pc_adv, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
